// File: rtl/cpu_debug_pkg.sv
// Shared debug-port encodings for the CPU and its dump host.
// Mode, status, stream tag and host state definitions.
package cpu_debug_pkg;

  localparam logic [1:0] RUN_MODE    = 2'd0;
  localparam logic [1:0] RESET_MODE  = 2'd1;
  localparam logic [1:0] UPLOAD_MODE = 2'd2;
  localparam logic [1:0] STATUS_MODE = 2'd3;

  localparam logic [1:0] STAT_ALLOK  = 2'd0;
  localparam logic [1:0] STAT_BUBBLE = 2'd1;
  localparam logic [1:0] STAT_STALL  = 2'd2;
  localparam logic [1:0] STAT_STOP   = 2'd3;

  localparam logic [1:0] KIND_MEM    = 2'd0;
  localparam logic [1:0] KIND_REG    = 2'd1;
  localparam logic [1:0] KIND_CYCLES = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CPURST,
    S_RUN,
    S_MADDR,
    S_MWAIT,
    S_MOUT,
    S_RADDR,
    S_RWAIT,
    S_ROUT,
    S_COUT,
    S_DONE
  } host_state_e;

  function automatic logic state_busy(
    input host_state_e s
  );
    return !(s == S_IDLE || s == S_DONE);
  endfunction

endpackage

// File: rtl/dump_stream_reg.sv
// Output holding register for the dump stream.
// A load always wins over the handshake that empties the slot.
module dump_stream_reg
  import cpu_debug_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  kind_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [1:0]  kind_o,
  output logic        fire_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  kind_q, kind_d;

  assign fire_o = valid_q && ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    kind_d  = kind_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      kind_d  = kind_i;
    end else if (fire_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      kind_q  <= KIND_MEM;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign kind_o  = kind_q;

endmodule

// File: rtl/cpu_dump_host.sv
// Debug-port initiator: resets and runs the CPU, then streams
// memory, register file and the run cycle count to a sink.
module cpu_dump_host
  import cpu_debug_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 512,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned RST_CYCLES = 2,
  parameter logic [31:0] MAX_CYCLES = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [1:0]  mode,
  output logic [31:0] udaddr,
  input  logic [31:0] odata,
  input  logic [1:0]  stat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_kind,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] n_cycle
);

  localparam logic [31:0] LAST_MEM = 32'(MEM_WORDS - 1);
  localparam logic [31:0] LAST_REG = 32'(REG_COUNT - 1);
  localparam logic [31:0] LAST_RST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LAST_RUN = MAX_CYCLES - 32'd1;

  host_state_e state_q, state_d;

  logic [1:0]  mode_q, mode_d;
  logic [31:0] udaddr_q, udaddr_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic [31:0] ncyc_q, ncyc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tout_q, tout_d;

  logic        ld;
  logic [31:0] ld_data;
  logic [1:0]  ld_kind;
  logic        hs;

  logic is_stop;
  logic at_limit;
  logic last_mem;
  logic last_reg;

  assign is_stop  = (stat == STAT_STOP);
  assign at_limit = (ncyc_q == LAST_RUN);
  assign last_mem = (idx_q == LAST_MEM);
  assign last_reg = (idx_q == LAST_REG);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_CPURST;
      end
      S_CPURST: begin
        if (rcnt_q == LAST_RST) state_d = S_RUN;
      end
      S_RUN: begin
        if (is_stop || at_limit) state_d = S_MADDR;
      end
      S_MADDR: state_d = S_MWAIT;
      S_MWAIT: state_d = S_MOUT;
      S_MOUT: begin
        if (hs) state_d = last_mem ? S_RADDR : S_MADDR;
      end
      S_RADDR: state_d = S_RWAIT;
      S_RWAIT: state_d = S_ROUT;
      S_ROUT: begin
        if (hs) state_d = last_reg ? S_COUT : S_RADDR;
      end
      S_COUT: begin
        if (hs) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and mode are set on entry to MADDR/RADDR so the CPU
  // has registered them by the MWAIT/RWAIT cycle.
  always_comb begin
    mode_d   = mode_q;
    udaddr_d = udaddr_q;
    idx_d    = idx_q;
    rcnt_d   = rcnt_q;
    ncyc_d   = ncyc_q;
    done_d   = done_q;
    tout_d   = tout_q;
    ld       = 1'b0;
    ld_data  = odata;
    ld_kind  = KIND_MEM;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d = 1'b0;
          tout_d = 1'b0;
          ncyc_d = '0;
          rcnt_d = '0;
          idx_d  = '0;
          mode_d = RESET_MODE;
        end
      end
      S_CPURST: begin
        rcnt_d = rcnt_q + 32'd1;
        if (rcnt_q == LAST_RST) mode_d = RUN_MODE;
      end
      S_RUN: begin
        unique case (stat)
          STAT_STOP: begin
            mode_d   = UPLOAD_MODE;
            udaddr_d = '0;
            idx_d    = '0;
          end
          STAT_ALLOK, STAT_BUBBLE, STAT_STALL: begin
            ncyc_d = ncyc_q + 32'd1;
            if (at_limit) begin
              tout_d   = 1'b1;
              mode_d   = UPLOAD_MODE;
              udaddr_d = '0;
              idx_d    = '0;
            end
          end
          default: ;
        endcase
      end
      S_MWAIT: begin
        ld      = 1'b1;
        ld_kind = KIND_MEM;
      end
      S_MOUT: begin
        if (hs) begin
          if (last_mem) begin
            idx_d    = '0;
            udaddr_d = '0;
            mode_d   = STATUS_MODE;
          end else begin
            idx_d    = idx_q + 32'd1;
            udaddr_d = idx_q + 32'd1;
          end
        end
      end
      S_RWAIT: begin
        ld      = 1'b1;
        ld_kind = KIND_REG;
      end
      S_ROUT: begin
        if (hs) begin
          if (last_reg) begin
            ld      = 1'b1;
            ld_data = ncyc_q;
            ld_kind = KIND_CYCLES;
          end else begin
            idx_d    = idx_q + 32'd1;
            udaddr_d = (idx_q + 32'd1) << 2;
          end
        end
      end
      S_COUT: begin
        if (hs) begin
          done_d = 1'b1;
          mode_d = RESET_MODE;
        end
      end
      default: ;
    endcase
  end

  assign busy_d = state_busy(state_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= RESET_MODE;
      udaddr_q <= '0;
      idx_q    <= '0;
      rcnt_q   <= '0;
      ncyc_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      udaddr_q <= udaddr_d;
      idx_q    <= idx_d;
      rcnt_q   <= rcnt_d;
      ncyc_q   <= ncyc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
    end
  end

  dump_stream_reg u_out (
    .clock   (clock),
    .reset   (reset),
    .load_i  (ld),
    .data_i  (ld_data),
    .kind_i  (ld_kind),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .kind_o  (out_kind),
    .fire_o  (hs)
  );

  assign mode    = mode_q;
  assign udaddr  = udaddr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = tout_q;
  assign n_cycle = ncyc_q;

endmodule

// File: doc/cpu_dump_host.md
Name: cpu_dump_host

Overview:
Hardware host for the CPU debug port (mode/udaddr/odata/stat). The CPU is the responder on that port; this block is the initiator that drives it.
- Holds the CPU in reset, runs it until stat reports STOP, then reads back main memory (UPLOAD mode) and the register file (STATUS mode).
- Emits every word plus the run cycle count on a valid/ready output stream.
- Replaces the behavioural bench sequence on FPGA builds and feeds a UART/logging sink.

Parameters:
- MEM_WORDS, 512, number of memory words read; udaddr steps 0..MEM_WORDS-1 by 1.
- REG_COUNT, 32, number of registers read; udaddr steps 0..4*(REG_COUNT-1) by 4.
- RST_CYCLES, 2, cycles mode is held at RESET before RUN (minimum 1).
- MAX_CYCLES, 32'hFFFF_FFFF, RUN cycle limit before forced timeout.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a session when idle or done.
- mode  out  2  CPU mode: RUN=0, RESET=1, UPLOAD=2, STATUS=3.
- udaddr  out  32  CPU debug address.
- odata  in  32  CPU debug read data; 1-cycle latency after udaddr/mode are registered.
- stat  in  2  CPU status: ALLOK=0, BUBBLE=1, STALL=2, STOP=3.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts the word when valid and ready are both high.
- out_data  out  32  stream word.
- out_kind  out  2  tag: 0=memory word, 1=register word, 2=cycle count.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  sticky; high in DONE until the next start or reset.
- timeout  out  1  sticky; set when RUN hit MAX_CYCLES; cleared by start or reset.
- n_cycle  out  32  RUN cycle count; live while running, frozen afterwards.

Behaviour:
- Reset values: mode=RESET(1), udaddr=0, out_valid=0, out_data=0, out_kind=0, busy=0, done=0, timeout=0, n_cycle=0; state=IDLE.
- Reset mid-session aborts immediately to the reset values. No partial word remains valid.
- All outputs are registered.
- States: IDLE, CPURST, RUN, MADDR, MWAIT, MOUT, RADDR, RWAIT, ROUT, COUT, DONE.
- IDLE/DONE on start: clear done, timeout and n_cycle; enter CPURST with mode=RESET. start is ignored while busy.
- CPURST: hold mode=RESET for RST_CYCLES cycles, then set mode=RUN and enter RUN.
- RUN, evaluated on each edge:
  - stat==STOP: go to MADDR; n_cycle is not incremented on that edge.
  - else if n_cycle==MAX_CYCLES-1: increment n_cycle, set timeout, go to MADDR.
  - else: increment n_cycle.
  - stat BUBBLE and STALL count as ordinary cycles.
- MADDR: mode=UPLOAD, udaddr=index (index starts at 0).
- MWAIT: one cycle for read latency. odata is captured into out_data on the edge leaving MWAIT; out_valid=1 and out_kind=0 on entry to MOUT.
- MOUT: hold out_data, out_kind, udaddr and mode until out_ready. On the handshake edge, drop out_valid, then:
  - if index==MEM_WORDS-1: index=0, go to RADDR;
  - else: index+1, go to MADDR.
- RADDR/RWAIT/ROUT: same pattern with mode=STATUS, udaddr=4*index, out_kind=1, ending at index==REG_COUNT-1.
- COUT: out_data=n_cycle, out_kind=2, out_valid=1. On handshake go to DONE, set done, set mode=RESET.
- Throughput: 3 cycles per word when out_ready is held high. Backpressure has no upper bound and no word is dropped or duplicated.
- A stat change outside RUN is ignored.
- A start pulse on the same edge as reset is ignored; reset wins.
- Output stream order: MEM_WORDS memory words, then REG_COUNT register words, then 1 count word.

Decomposition:
- Shared package cpu_debug_pkg:
  - mode constants RUN_MODE, RESET_MODE, UPLOAD_MODE, STATUS_MODE;
  - status constants STAT_ALLOK, STAT_BUBBLE, STAT_STALL, STAT_STOP;
  - out_kind constants KIND_MEM, KIND_REG, KIND_CYCLES;
  - host state enum.
- The package is also to be used by the CPU top.
- One sub-module, dump_stream_reg: a 32+2-bit output holding register with the valid/ready handshake. It is used for MOUT, ROUT and COUT.

Test Plan:
- CPU model that asserts STOP after 10 RUN cycles, memory word i = i ^ 32'hA5A5_0000, register r = r*3, out_ready=1. Required:
  - 512 KIND_MEM words in order with matching data;
  - 32 KIND_REG words with udaddr 0,4,...,124;
  - final KIND_CYCLES word = 10 and n_cycle=10;
  - done=1, busy=0, mode=RESET;
  - 545 handshakes total.
- Same run with out_ready toggling pseudo-randomly (held low up to 20 cycles). Required: identical 545-word sequence, and out_data/udaddr/mode stable whenever out_valid=1 and out_ready=0.
- stat stuck at ALLOK with MAX_CYCLES=100. Required: timeout=1, n_cycle=100, full dump still produced, count word = 100.
- stat==STOP already on the first RUN edge. Required: n_cycle=0, count word = 0.
- Reset asserted during the MOUT of memory word 200. Required: next cycle out_valid=0, mode=RESET, udaddr=0, busy=0. A new start then produces the full sequence starting at word 0.
- start pulsed during RUN and during MOUT. Required: ignored, with no restart and no change to n_cycle or to the stream.
